// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle teaching-CPU sequencer.
//   state_t    : sequencer FSM states
//   OP_*       : opcode field values (IR[7:6])
//   HALT_WORD  : instruction word that parks the sequencer in HALT
//   CTRL_OP*   : datapath control word driven during EXEC, per opcode
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      WB,
      HALT
   } state_t;

   localparam logic [1:0] OP_0   = 2'b00;
   localparam logic [1:0] OP_1   = 2'b01;
   localparam logic [1:0] OP_2   = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   localparam logic [7:0] HALT_WORD = 8'hFF;

   localparam logic [7:0] CTRL_OP0 = 8'hC1;
   localparam logic [7:0] CTRL_OP1 = 8'h6A;
   localparam logic [7:0] CTRL_OP2 = 8'h24;
   localparam logic [7:0] CTRL_OP3 = 8'h10;

   function automatic logic [7:0] ctrl_word(input logic [1:0] opcode);
      logic [7:0] word;
      case (opcode)
         OP_0:    word = CTRL_OP0;
         OP_1:    word = CTRL_OP1;
         OP_2:    word = CTRL_OP2;
         default: word = CTRL_OP3;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_pc_unit.sv
// Program counter for the multi-cycle sequencer.
//   clk_sys  : system clock
//   rst      : synchronous active-high clear (PC -> 0)
//   inc      : advance PC by one (fetch handshake), wraps modulo 2^PC_W
//   load     : load PC from load_val (jump); wins over inc
//   load_val : jump target
//   pc       : current program counter
module pc_unit #(
   parameter int PC_W = 6
) (
   input  logic            clk_sys,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: fetches one instruction word over a ready
// handshake, holds it in IR, and steps the datapath through
// FETCH/DECODE/EXEC/WB. Owns the PC (via pc_unit), handles jump and halt.
//   CLK, RST            : clock, synchronous active-high reset
//   RUN                 : start request, sampled only in IDLE
//   STOP                : stop request, sampled only at an instruction boundary
//   IMEM_REQ/ADDR/RDY/DATA : instruction fetch handshake (transfer on REQ && RDY)
//   OPCODE, OPERAND     : fields of the instruction register
//   CTRL                : datapath control word, non-zero only in EXEC
//   WB_EN               : one-cycle write-back strobe
//   BUSY, HALTED        : status
//   INSTR_CNT           : retired instructions, saturating
//
// state  | meaning
// IDLE   | waiting for RUN; PC kept so a stopped program resumes
// FETCH  | IMEM_REQ held with ADDR=PC until IMEM_RDY
// DECODE | one cycle; HALT_WORD diverts to HALT
// EXEC   | CTRL driven for EXEC_CYCLES cycles; jumps retire on the last one
// WB     | WB_EN strobe; instruction retires
// HALT   | absorbing until RST
module multicycle_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_W        = 6,
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RUN,
   input  logic             STOP,
   output logic             IMEM_REQ,
   output logic [PC_W-1:0]  IMEM_ADDR,
   input  logic             IMEM_RDY,
   input  logic [7:0]       IMEM_DATA,
   output logic [1:0]       OPCODE,
   output logic [PC_W-1:0]  OPERAND,
   output logic [7:0]       CTRL,
   output logic             WB_EN,
   output logic             BUSY,
   output logic             HALTED,
   output logic [CNT_W-1:0] INSTR_CNT
);

   // Down-counter preload: terminal count 0 marks the last EXEC cycle.
   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       ir;
   logic [3:0]       exec_cnt;
   logic [CNT_W-1:0] instr_cnt;
   logic [PC_W-1:0]  pc;
   logic             fetch_xfer;
   logic             is_jump;
   logic             exec_last;
   logic             pc_load;
   logic             boundary;

   assign fetch_xfer = (state == FETCH) && IMEM_RDY;
   assign is_jump    = (ir[7:6] == OP_JMP);
   assign exec_last  = (state == EXEC) && (exec_cnt == 4'd0);
   assign pc_load    = exec_last && is_jump;
   assign boundary   = (state == WB) || pc_load;

   pc_unit #(
      .PC_W(PC_W)
   ) u_pc (
      .clk_sys (CLK),
      .rst     (RST),
      .inc     (fetch_xfer),
      .load    (pc_load),
      .load_val(ir[PC_W-1:0]),
      .pc      (pc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         ir        <= '0;
         exec_cnt  <= '0;
         instr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (fetch_xfer) begin
            ir <= IMEM_DATA;
         end
         if (state == DECODE) begin
            exec_cnt <= EXEC_LOAD;
         end else if ((state == EXEC) && (exec_cnt != 4'd0)) begin
            exec_cnt <= exec_cnt - 4'd1;
         end
         if (boundary && (instr_cnt != '1)) begin
            instr_cnt <= instr_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      IMEM_REQ  = 1'b0;
      CTRL      = 8'h00;
      WB_EN     = 1'b0;
      BUSY      = 1'b1;
      HALTED    = 1'b0;
      case (state)
         IDLE: begin
            BUSY = 1'b0;
            if (RUN) state_nxt = FETCH;
         end
         FETCH: begin
            IMEM_REQ = 1'b1;
            if (IMEM_RDY) state_nxt = DECODE;
         end
         DECODE: begin
            state_nxt = (ir == HALT_WORD) ? HALT : EXEC;
         end
         EXEC: begin
            CTRL = ctrl_word(ir[7:6]);
            if (exec_cnt == 4'd0) begin
               if (is_jump) state_nxt = STOP ? IDLE : FETCH;
               else         state_nxt = WB;
            end
         end
         WB: begin
            WB_EN     = 1'b1;
            state_nxt = STOP ? IDLE : FETCH;
         end
         HALT: begin
            BUSY   = 1'b0;
            HALTED = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign IMEM_ADDR = pc;
   assign OPCODE    = ir[7:6];
   assign OPERAND   = ir[PC_W-1:0];
   assign INSTR_CNT = instr_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Two sequencer instances share stimulus and instruction memory:
//   dut0 : EXEC_CYCLES=1, CNT_W=8
//   dut1 : EXEC_CYCLES=3, CNT_W=2 (counter saturates at 3)
// A per-instruction timing model (cycles elapsed since the fetch handshake)
// predicts every output each cycle; directed steps pin the model with
// hand-computed literals.
module tb_multicycle_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RUN = 1'b0;
   logic       STOP = 1'b0;
   logic       RDY = 1'b1;
   logic [7:0] mem [64];

   logic       req0, req1, wb0, wb1, busy0, busy1, halt0, halt1;
   logic [5:0] addr0, addr1, opr0, opr1;
   logic [1:0] opc0, opc1;
   logic [7:0] ctrl0, ctrl1, data0, data1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   assign data0 = mem[addr0];
   assign data1 = mem[addr1];

   multicycle_sequencer #(.PC_W(6), .EXEC_CYCLES(1), .CNT_W(8)) dut0 (
      .CLK(CLK), .RST(RST), .RUN(RUN), .STOP(STOP),
      .IMEM_REQ(req0), .IMEM_ADDR(addr0), .IMEM_RDY(RDY), .IMEM_DATA(data0),
      .OPCODE(opc0), .OPERAND(opr0), .CTRL(ctrl0), .WB_EN(wb0),
      .BUSY(busy0), .HALTED(halt0), .INSTR_CNT(cnt0)
   );

   multicycle_sequencer #(.PC_W(6), .EXEC_CYCLES(3), .CNT_W(2)) dut1 (
      .CLK(CLK), .RST(RST), .RUN(RUN), .STOP(STOP),
      .IMEM_REQ(req1), .IMEM_ADDR(addr1), .IMEM_RDY(RDY), .IMEM_DATA(data1),
      .OPCODE(opc1), .OPERAND(opr1), .CTRL(ctrl1), .WB_EN(wb1),
      .BUSY(busy1), .HALTED(halt1), .INSTR_CNT(cnt1)
   );

   // ---------------- reference model ----------------
   // mode: 0 stopped, 1 running, 2 halted
   // t   : -1 while waiting for the fetch handshake, else cycles since it
   int         m_ecyc [2] = '{1, 3};
   int         m_smax [2] = '{255, 3};
   int         m_mode [2] = '{0, 0};
   int         m_t    [2] = '{-1, -1};
   int         m_cnt  [2] = '{0, 0};
   logic [5:0] m_pc   [2] = '{6'd0, 6'd0};
   logic [7:0] m_ir   [2] = '{8'd0, 8'd0};

   function automatic logic [7:0] exp_ctrl(input logic [1:0] op);
      case (op)
         2'd0:    return 8'hC1;
         2'd1:    return 8'h6A;
         2'd2:    return 8'h24;
         default: return 8'h10;
      endcase
   endfunction

   always @(posedge CLK) begin : model
      int  last;
      bit  jmp;
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            m_mode[i] = 0; m_t[i] = -1; m_cnt[i] = 0;
            m_pc[i] = 6'd0; m_ir[i] = 8'd0;
         end else if (m_mode[i] == 0) begin
            if (RUN) begin
               m_mode[i] = 1; m_t[i] = -1;
            end
         end else if (m_mode[i] == 1) begin
            if (m_t[i] < 0) begin
               if (RDY) begin
                  m_ir[i] = mem[m_pc[i]];
                  m_pc[i] = m_pc[i] + 6'd1;
                  m_t[i]  = 1;
               end
            end else if (m_t[i] == 1) begin
               if (m_ir[i] == 8'hFF) m_mode[i] = 2;
               else                  m_t[i] = 2;
            end else begin
               jmp  = (m_ir[i][7:6] == 2'b11);
               last = jmp ? m_ecyc[i] + 1 : m_ecyc[i] + 2;
               if (m_t[i] == last) begin
                  if (jmp) m_pc[i] = m_ir[i][5:0];
                  if (m_cnt[i] < m_smax[i]) m_cnt[i]++;
                  m_mode[i] = STOP ? 0 : 1;
                  m_t[i]    = -1;
               end else begin
                  m_t[i]++;
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int inst, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic req, input logic [5:0] addr,
                           input logic [1:0] opc, input logic [5:0] opr,
                           input logic [7:0] ctrl, input logic wb, input logic busy,
                           input logic halted, input int cnt);
      bit run;
      int t;
      run = (m_mode[i] == 1);
      t   = m_t[i];
      check("req",     i, int'(req),    int'(run && t < 0));
      check("addr",    i, int'(addr),   int'(m_pc[i]));
      check("opcode",  i, int'(opc),    int'(m_ir[i][7:6]));
      check("operand", i, int'(opr),    int'(m_ir[i][5:0]));
      check("ctrl",    i, int'(ctrl),
            (run && t >= 2 && t <= m_ecyc[i] + 1) ? int'(exp_ctrl(m_ir[i][7:6])) : 0);
      check("wb_en",   i, int'(wb),     int'(run && t == m_ecyc[i] + 2));
      check("busy",    i, int'(busy),   int'(run));
      check("halted",  i, int'(halted), int'(m_mode[i] == 2));
      check("instr_cnt", i, cnt, m_cnt[i]);
   endtask

   always @(negedge CLK) begin
      cmp_inst(0, req0, addr0, opc0, opr0, ctrl0, wb0, busy0, halt0, int'(cnt0));
      cmp_inst(1, req1, addr1, opc1, opr1, ctrl1, wb1, busy1, halt1, int'(cnt1));
   end

   // ---------------- directed + random stimulus ----------------
   task automatic tick();
      @(negedge CLK);
   endtask

   initial begin
      bit seen;
      for (int k = 0; k < 64; k++) mem[k] = 8'h00;
      mem[0] = 8'h05;
      mem[1] = 8'hC0;
      repeat (2) tick();

      // first ALU instruction, then JUMP 0
      RST = 0; RUN = 1;
      tick();                                   // FETCH
      check("lit_req", 0, int'(req0), 1); check("lit_addr", 0, int'(addr0), 0);
      check("lit_req", 1, int'(req1), 1); check("lit_addr", 1, int'(addr1), 0);
      RUN = 0;
      tick();                                   // DECODE
      check("lit_opcode", 0, int'(opc0), 0); check("lit_operand", 0, int'(opr0), 5);
      tick();                                   // EXEC
      check("lit_ctrl", 0, int'(ctrl0), 'hC1); check("lit_ctrl", 1, int'(ctrl1), 'hC1);
      tick();                                   // WB (dut0)
      check("lit_wb", 0, int'(wb0), 1); check("lit_ctrl_wb", 0, int'(ctrl0), 0);
      tick();                                   // dut0 next FETCH
      check("lit_cnt", 0, int'(cnt0), 1); check("lit_addr", 0, int'(addr0), 1);
      check("lit_req", 0, int'(req0), 1);
      repeat (4) tick();                        // dut1 enters jump EXEC
      for (int j = 0; j < 3; j++) begin
         check("lit_jctrl", 1, int'(ctrl1), 'h10); check("lit_jwb", 1, int'(wb1), 0);
         tick();
      end
      check("lit_jaddr", 1, int'(addr1), 0); check("lit_jreq", 1, int'(req1), 1);
      check("lit_jcnt", 1, int'(cnt1), 2);

      // fetch wait: RDY low 5 cycles
      RDY = 0;
      for (int j = 0; j < 5; j++) begin
         tick();
         check("lit_wreq", 0, int'(req0), 1);  check("lit_waddr", 0, int'(addr0), 1);
         check("lit_wreq", 1, int'(req1), 1);  check("lit_waddr", 1, int'(addr1), 0);
         check("lit_wir", 1, int'(opc1), 3);
      end
      RST = 1;                                  // reset mid fetch-wait
      tick();
      check("lit_rst_out", 0, int'({req0, addr0, opc0, opr0, ctrl0, wb0, busy0, halt0, cnt0}), 0);
      check("lit_rst_out", 1, int'({req1, addr1, opc1, opr1, ctrl1, wb1, busy1, halt1, cnt1}), 0);

      // stop / resume
      mem[1] = 8'h01; mem[2] = 8'h02;
      RST = 0; RUN = 1; RDY = 1;
      tick(); RUN = 0;                          // b1
      tick();                                   // b2
      tick(); STOP = 1;                         // b3: pulse during EXEC
      tick(); STOP = 0;                         // b4
      tick();                                   // b5
      check("lit_stop_ign", 0, int'(addr0), 1); check("lit_stop_req", 0, int'(req0), 1);
      STOP = 1;
      tick();                                   // b6
      tick();                                   // b7
      check("lit_idle_busy", 1, int'(busy1), 0); check("lit_idle_pc", 1, int'(addr1), 1);
      tick();                                   // b8
      tick();                                   // b9
      check("lit_idle_busy", 0, int'(busy0), 0); check("lit_idle_pc", 0, int'(addr0), 2);
      RUN = 1;                                  // RUN with STOP still high
      tick();                                   // b10
      check("lit_resume", 0, int'({req0, addr0}), int'({1'b1, 6'd2}));
      check("lit_resume", 1, int'({req1, addr1}), int'({1'b1, 6'd1}));
      RUN = 0; STOP = 0; RST = 1;
      tick();

      // halt
      mem[0] = 8'h05; mem[1] = 8'h01; mem[2] = 8'hFF;
      RST = 0; RUN = 1;
      for (int k = 0; k < 80 && !(halt0 && halt1); k++) tick();
      check("lit_halt_reached", 0, int'(halt0 && halt1), 1);
      STOP = 1;
      repeat (3) tick();
      check("lit_halted", 0, int'(halt0), 1); check("lit_hbusy", 0, int'(busy0), 0);
      check("lit_hctrl", 0, int'(ctrl0), 0);  check("lit_hcnt", 0, int'(cnt0), 2);
      check("lit_halted", 1, int'(halt1), 1); check("lit_hcnt", 1, int'(cnt1), 2);
      RST = 1; RUN = 0; STOP = 0;
      tick();
      check("lit_hrst", 0, int'({halt0, busy0, addr0, cnt0}), 0);
      check("lit_hrst", 1, int'({halt1, busy1, addr1, cnt1}), 0);

      // PC wrap 63 -> 0
      RST = 0;
      for (int k = 0; k < 64; k++) mem[k] = 8'(((k % 3) * 64) + k);
      RUN = 1;
      tick(); RUN = 0;
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         if (req0 && addr0 == 6'd63) seen = 1;
         else tick();
      end
      check("lit_reach63", 0, int'(seen), 1);
      for (int k = 0; k < 10 && req0; k++) tick();
      for (int k = 0; k < 10 && !req0; k++) tick();
      check("lit_wrap", 0, int'({req0, addr0}), int'({1'b1, 6'd0}));

      // tight jump loop, counter saturation, reset mid-EXEC
      RST = 1;
      tick();
      RST = 0; mem[0] = 8'hC0; RUN = 1;
      tick(); RUN = 0;
      repeat (40) tick();
      check("lit_sat", 1, int'(cnt1), 3); check("lit_loop_addr", 1, int'(addr1), 0);
      for (int k = 0; k < 10 && ctrl1 == 8'h00; k++) tick();
      check("lit_loop_ctrl", 1, int'(ctrl1), 'h10);
      RST = 1;
      tick();
      check("lit_rst_exec", 1, int'({req1, addr1, opc1, opr1, ctrl1, wb1, busy1, halt1, cnt1}), 0);

      // randomized run
      for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
      RST = 0;
      repeat (3000) begin
         RST  = ($urandom_range(0, 99) < 2);
         RUN  = ($urandom_range(0, 99) < 50);
         STOP = ($urandom_range(0, 99) < 25);
         RDY  = ($urandom_range(0, 99) < 70);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit teaching CPU. It fetches one instruction word per instruction from instruction memory over a ready handshake, holds it in an instruction register, and steps the datapath through FETCH/DECODE/EXEC/WB. It drives the datapath control word only during EXEC, owns the program counter, and handles jump and halt. It sits between instruction memory and the datapath, in place of a free-running decode.

Parameters:
PC_W, 6, program counter / instruction address width (instruction operand field width)
EXEC_CYCLES, 1, cycles the control word is held in EXEC; legal 1..15
CNT_W, 8, width of retired-instruction counter

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous active-high reset
RUN  input  1  start request, sampled only in IDLE
STOP  input  1  stop request, sampled only at instruction boundary (last WB or jump EXEC cycle)
IMEM_REQ  output  1  instruction read request
IMEM_ADDR  output  PC_W  instruction address (= PC)
IMEM_RDY  input  1  memory ready; transfer when IMEM_REQ && IMEM_RDY
IMEM_DATA  input  8  instruction word {opcode[7:6], operand[5:0]}
OPCODE  output  2  IR[7:6], valid from DECODE onward
OPERAND  output  PC_W  IR[PC_W-1:0]
CTRL  output  8  datapath control word, 8'h00 outside EXEC
WB_EN  output  1  one-cycle register write-back strobe
BUSY  output  1  state not IDLE and not HALT
HALTED  output  1  high in HALT
INSTR_CNT  output  CNT_W  retired instructions, saturating

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST). RST wins over every other input in the same cycle, including mid-instruction and mid-handshake.
- Reset values: state=IDLE, PC=0, IR=0, exec counter=0, INSTR_CNT=0, and all outputs 0.
- States and transitions:
  - IDLE: RUN=1 -> FETCH. PC is not cleared, so a stopped program resumes at the next instruction.
  - FETCH: IMEM_REQ=1 and IMEM_ADDR=PC, held stable until the handshake.
    - On the IMEM_RDY=1 cycle: IR<=IMEM_DATA, PC<=PC+1 (modulo 2^PC_W, 63->0), then -> DECODE.
    - IMEM_RDY=0 holds FETCH indefinitely.
    - IMEM_RDY and IMEM_DATA are ignored in every other state.
  - DECODE: 1 cycle, then -> EXEC; except IR==8'hFF -> HALT (not counted as retired).
  - EXEC: CTRL=CTRL_TABLE[OPCODE] for exactly EXEC_CYCLES cycles, counted by the exec counter.
    - Opcodes 00/01/10: on the last cycle -> WB.
    - Opcode 11 (JUMP): PC<=OPERAND on the last cycle, no WB, then boundary.
  - WB: WB_EN=1 for 1 cycle, CTRL=0, then boundary.
  - Boundary: INSTR_CNT += 1 (holds at 2^CNT_W-1). Next state is IDLE if STOP=1 that cycle, else FETCH.
  - HALT: absorbing, left only by RST. HALTED=1, BUSY=0, CTRL=0.
- Latency with IMEM_RDY tied high:
  - ALU/load-type instruction: 3+EXEC_CYCLES cycles.
  - JUMP: 2+EXEC_CYCLES cycles.
  - Each cycle IMEM_RDY is low adds one cycle.
- Edge cases:
  - RUN and STOP together in IDLE: RUN wins, because STOP is not sampled in IDLE.
  - STOP outside the boundary cycle is ignored; it must be held by the requester.
  - A JUMP to the current address forms a legal tight loop.
- All outputs are registered or decoded from state/IR only; no combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - State enum: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - Opcode constants: OP_0=2'b00, OP_1=2'b01, OP_2=2'b10, OP_JMP=2'b11.
  - HALT_WORD=8'hFF.
  - Control-word constants: CTRL_OP0=8'hC1, CTRL_OP1=8'h6A, CTRL_OP2=8'h24, CTRL_OP3=8'h10.
- One natural sub-module: pc_unit. It holds the PC register, increments on the fetch handshake, loads on jump, and clears on reset.
- The FSM, exec counter and instruction counter stay in the top module.

Test Plan:
- Reset, RUN=1, IMEM_RDY=1, memory[0]=8'h05 -> IMEM_ADDR=0 in FETCH; CTRL=8'hC1 for exactly 1 cycle; WB_EN pulse one cycle later; INSTR_CNT=1; next fetch at addr 1; 4 cycles total.
- memory[1]=8'hC0 (JUMP 0) with EXEC_CYCLES=3 -> CTRL=8'h10 for 3 cycles; no WB_EN; next IMEM_ADDR=0.
- IMEM_RDY low for 5 cycles in FETCH -> IMEM_REQ and IMEM_ADDR stable the whole time; IR unchanged until the handshake cycle; instruction latency +5.
- memory[2]=8'hFF -> HALT after DECODE; HALTED=1, BUSY=0, CTRL=0; INSTR_CNT unchanged; RUN/STOP ignored; RST returns to IDLE with PC=0.
- Stop/restart and wrap:
  - STOP pulsed during EXEC -> ignored.
  - STOP held through WB -> IDLE, PC preserved; RUN resumes at the preserved PC.
  - PC wraps 63->0 after fetching address 63.
- RST asserted mid-EXEC and mid-FETCH-wait -> next cycle all outputs 0, state IDLE; CNT_W=2 bench saturates INSTR_CNT at 3.
